// File: rtl/pic_ack_sequencer_if.sv
// Signal bundle between the interrupt controller core / CPU bus and the 8086-mode
// acknowledge sequencer. The sequencer is the slave side.
interface pic_ack_sequencer_if;
  logic [7:0] pending_request;
  logic [7:0] in_service_register;
  logic [7:0] highest_level_in_service;
  logic       inta_n;
  logic [4:0] vector_base;
  logic       auto_eoi;
  logic       ocw2_write;
  logic [7:0] ocw2_data;
  logic       int_out;
  logic       latch_in_service;
  logic [7:0] interrupt;
  logic [7:0] end_of_interrupt;
  logic [2:0] priority_rotate;
  logic [7:0] data_out;
  logic       data_out_en;

  modport master (
    output pending_request, in_service_register, highest_level_in_service, inta_n,
    output vector_base, auto_eoi, ocw2_write, ocw2_data,
    input  int_out, latch_in_service, interrupt, end_of_interrupt, priority_rotate,
    input  data_out, data_out_en
  );

  modport slave (
    input  pending_request, in_service_register, highest_level_in_service, inta_n,
    input  vector_base, auto_eoi, ocw2_write, ocw2_data,
    output int_out, latch_in_service, interrupt, end_of_interrupt, priority_rotate,
    output data_out, data_out_en
  );
endinterface

// File: rtl/pic_ack_sequencer.sv
// 8086-mode INTA sequencer: priority resolution, two-pulse acknowledge handshake,
// vector output, AEOI and OCW2 end-of-interrupt / rotation handling.
module pic_ack_sequencer #(
  parameter int unsigned ACK_TIMEOUT    = 255,
  parameter logic [2:0]  SPURIOUS_LEVEL = 3'd7
) (
  input logic                clk,
  input logic                reset,
  pic_ack_sequencer_if.slave bus
);
  localparam int unsigned   TW         = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT1 = 3'd1,
    ACK1  = 3'd2,
    WAIT2 = 3'd3,
    ACK2  = 3'd4
  } state_t;

  // Distance from the current highest-priority level; smaller means higher priority.
  function automatic logic [2:0] rank(input logic [2:0] lvl, input logic [2:0] rot);
    rank = lvl - rot - 3'd1;
  endfunction

  function automatic logic [2:0] top_level(input logic [7:0] req, input logic [2:0] rot);
    logic [2:0] lvl;
    top_level = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      lvl = rot + 3'd1 + 3'(i);
      if (req[lvl]) top_level = lvl;
    end
  endfunction

  function automatic logic [2:0] onehot_index(input logic [7:0] oh);
    onehot_index = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) onehot_index = 3'(i);
    end
  endfunction

  state_t        state_q, state_d;
  logic          int_out_q, int_out_d;
  logic          latch_q, latch_d;
  logic [7:0]    interrupt_q, interrupt_d;
  logic [7:0]    eoi_q, eoi_d;
  logic [2:0]    rotate_q, rotate_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          data_en_q, data_en_d;
  logic          auto_rot_q, auto_rot_d;
  logic          inta_prev_q, inta_prev_d;
  logic [2:0]    level_q, level_d;
  logic          spur_q, spur_d;
  logic [TW-1:0] timer_q, timer_d;

  logic       req_valid;
  logic [2:0] top_pending;
  logic [2:0] top_isr;
  logic       inta_fall;
  logic       inta_rise;
  logic       timed_out;
  logic [2:0] ocw2_cmd;
  logic [2:0] ocw2_level;
  logic       unused_ocw2_bits;

  assign inta_fall        = inta_prev_q & ~bus.inta_n;
  assign inta_rise        = ~inta_prev_q & bus.inta_n;
  assign timed_out        = (timer_q == TIMER_LAST);
  assign ocw2_cmd         = bus.ocw2_write ? bus.ocw2_data[7:5] : 3'b010;
  assign ocw2_level       = bus.ocw2_data[2:0];
  assign unused_ocw2_bits = ^bus.ocw2_data[4:3];

  // Request resolution against the rotating priority and the in-service level.
  always_comb begin
    top_pending = top_level(bus.pending_request, rotate_q);
    top_isr     = onehot_index(bus.highest_level_in_service);
    if (bus.pending_request == 8'd0) begin
      req_valid = 1'b0;
    end else if (bus.in_service_register == 8'd0) begin
      req_valid = 1'b1;
    end else begin
      req_valid = (rank(top_pending, rotate_q) < rank(top_isr, rotate_q));
    end
  end

  // Acknowledge FSM next state plus OCW2 decode merged on top of it.
  always_comb begin
    state_d     = state_q;
    int_out_d   = int_out_q;
    latch_d     = 1'b0;
    interrupt_d = 8'd0;
    eoi_d       = 8'd0;
    rotate_d    = rotate_q;
    data_out_d  = data_out_q;
    data_en_d   = data_en_q;
    auto_rot_d  = auto_rot_q;
    inta_prev_d = bus.inta_n;
    level_d     = level_q;
    spur_d      = spur_q;
    timer_d     = timer_q + TW'(1);

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (req_valid) begin
          int_out_d = 1'b1;
          state_d   = WAIT1;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT1: begin
        if (inta_fall) begin
          int_out_d = 1'b0;
          timer_d   = '0;
          state_d   = ACK1;
          if (req_valid) begin
            latch_d     = 1'b1;
            interrupt_d = 8'd1 << top_pending;
            level_d     = top_pending;
            spur_d      = 1'b0;
          end else begin
            level_d = SPURIOUS_LEVEL;
            spur_d  = 1'b1;
          end
        end else if (timed_out) begin
          int_out_d = 1'b0;
          data_en_d = 1'b0;
          state_d   = IDLE;
        end else begin
          state_d = WAIT1;
        end
      end
      ACK1: begin
        if (inta_rise) begin
          timer_d = '0;
          state_d = WAIT2;
        end else if (timed_out) begin
          state_d = IDLE;
        end else begin
          state_d = ACK1;
        end
      end
      WAIT2: begin
        if (inta_fall) begin
          data_out_d = {bus.vector_base, level_q};
          data_en_d  = 1'b1;
          timer_d    = '0;
          state_d    = ACK2;
        end else if (timed_out) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT2;
        end
      end
      ACK2: begin
        if (inta_rise) begin
          data_en_d = 1'b0;
          state_d   = IDLE;
          if (bus.auto_eoi && !spur_q) begin
            eoi_d    = 8'd1 << level_q;
            rotate_d = auto_rot_q ? level_q : rotate_q;
          end else begin
            eoi_d = 8'd0;
          end
        end else if (timed_out) begin
          data_en_d = 1'b0;
          state_d   = IDLE;
        end else begin
          state_d = ACK2;
        end
      end
      default: begin
        int_out_d = 1'b0;
        data_en_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    // OCW2 is evaluated last so its rotation overrides an AEOI rotation.
    case (ocw2_cmd)
      3'b001: eoi_d = eoi_d | bus.highest_level_in_service;
      3'b011: eoi_d = eoi_d | (8'd1 << ocw2_level);
      3'b101: begin
        eoi_d    = eoi_d | bus.highest_level_in_service;
        rotate_d = (bus.highest_level_in_service != 8'd0) ? top_isr : rotate_d;
      end
      3'b111: begin
        eoi_d    = eoi_d | (8'd1 << ocw2_level);
        rotate_d = ocw2_level;
      end
      3'b110: rotate_d = ocw2_level;
      3'b100: auto_rot_d = 1'b1;
      3'b000: auto_rot_d = 1'b0;
      default: auto_rot_d = auto_rot_d;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      int_out_q   <= 1'b0;
      latch_q     <= 1'b0;
      interrupt_q <= 8'd0;
      eoi_q       <= 8'd0;
      rotate_q    <= 3'd7;
      data_out_q  <= 8'd0;
      data_en_q   <= 1'b0;
      auto_rot_q  <= 1'b0;
      inta_prev_q <= 1'b1;
      level_q     <= 3'd0;
      spur_q      <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      int_out_q   <= int_out_d;
      latch_q     <= latch_d;
      interrupt_q <= interrupt_d;
      eoi_q       <= eoi_d;
      rotate_q    <= rotate_d;
      data_out_q  <= data_out_d;
      data_en_q   <= data_en_d;
      auto_rot_q  <= auto_rot_d;
      inta_prev_q <= inta_prev_d;
      level_q     <= level_d;
      spur_q      <= spur_d;
      timer_q     <= timer_d;
    end
  end

  assign bus.int_out          = int_out_q;
  assign bus.latch_in_service = latch_q;
  assign bus.interrupt        = interrupt_q;
  assign bus.end_of_interrupt = eoi_q;
  assign bus.priority_rotate  = rotate_q;
  assign bus.data_out         = data_out_q;
  assign bus.data_out_en      = data_en_q;
endmodule

// File: tb/tb_pic_ack_sequencer.sv
// Self-checking bench for pic_ack_sequencer: directed scenarios plus randomized
// acknowledge cycles compared against a rule-level priority/EOI model.
module tb_pic_ack_sequencer;
  localparam int ACK_TIMEOUT = 255;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pic_ack_sequencer_if bus();

  pic_ack_sequencer #(.ACK_TIMEOUT(ACK_TIMEOUT), .SPURIOUS_LEVEL(3'd7)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int m_rot = 7;
  bit m_auto = 1'b0;

  // ---------------- model ----------------
  function automatic int rank_of(input int p, input int rot);
    return (p - rot - 1 + 16) % 8;
  endfunction

  function automatic int top_of(input logic [7:0] v, input int rot);
    int best = -1;
    for (int p = 0; p < 8; p++)
      if (v[p] && (best < 0 || rank_of(p, rot) < rank_of(best, rot))) best = p;
    return best;
  endfunction

  function automatic bit req_ok(input logic [7:0] pend, input logic [7:0] isr, input int rot);
    if (pend == 8'd0) return 1'b0;
    if (isr == 8'd0) return 1'b1;
    return rank_of(top_of(pend, rot), rot) < rank_of(top_of(isr, rot), rot);
  endfunction

  task automatic model_ocw2(input logic [7:0] d, input int hi, output logic [7:0] eoi);
    int l = int'(d[2:0]);
    eoi = 8'd0;
    case (d[7:5])
      3'b001: eoi = (hi >= 0) ? (8'd1 << hi) : 8'd0;
      3'b011: eoi = 8'd1 << l;
      3'b101: if (hi >= 0) begin eoi = 8'd1 << hi; m_rot = hi; end
      3'b111: begin eoi = 8'd1 << l; m_rot = l; end
      3'b110: m_rot = l;
      3'b100: m_auto = 1'b1;
      3'b000: m_auto = 1'b0;
      default: ;
    endcase
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.pending_request = 8'd0;
    bus.in_service_register = 8'd0;
    bus.highest_level_in_service = 8'd0;
    bus.inta_n = 1'b1;
    bus.vector_base = 5'd0;
    bus.auto_eoi = 1'b0;
    bus.ocw2_write = 1'b0;
    bus.ocw2_data = 8'd0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    drive_idle();
    step();
    step();
    reset = 1'b0;
    m_rot = 7;
    m_auto = 1'b0;
  endtask

  task automatic set_isr(input logic [7:0] isr, output int hi);
    hi = (isr == 8'd0) ? -1 : top_of(isr, m_rot);
    bus.in_service_register = isr;
    bus.highest_level_in_service = (hi < 0) ? 8'd0 : (8'd1 << hi);
  endtask

  task automatic ocw2(input logic [7:0] d, input int hi, output logic [7:0] exp_eoi);
    model_ocw2(d, hi, exp_eoi);
    bus.ocw2_write = 1'b1;
    bus.ocw2_data = d;
    step();
    bus.ocw2_write = 1'b0;
    bus.ocw2_data = 8'd0;
  endtask

  // One full acknowledge attempt; ocw_en issues an OCW2 on the INTA#2 rising edge.
  task automatic run_ack(input string tag, input logic [7:0] pend, input logic [7:0] isr,
                         input logic [4:0] base, input bit aeoi, input bit drop, input int gap,
                         input bit ocw_en, input logic [7:0] ocw);
    int lvl, hi;
    bit spur, want_int;
    logic [7:0] exp_int, exp_eoi, ocw_eoi;
    set_isr(isr, hi);
    bus.vector_base = base;
    bus.auto_eoi = aeoi;
    bus.pending_request = pend;
    want_int = req_ok(pend, isr, m_rot);
    step();
    checks++;
    if (bus.int_out !== want_int) begin
      failures++;
      $display("FAIL %s int_out: got %0b want %0b", tag, bus.int_out, want_int);
    end
    if (!want_int) begin
      bus.pending_request = 8'd0;
      step();
      return;
    end
    repeat (gap) step();
    if (drop) bus.pending_request = 8'd0;
    spur = !req_ok(bus.pending_request, isr, m_rot);
    lvl = spur ? 7 : top_of(bus.pending_request, m_rot);
    exp_int = spur ? 8'd0 : (8'd1 << lvl);
    bus.inta_n = 1'b0;
    step();
    checks++;
    if (bus.latch_in_service !== !spur || bus.interrupt !== exp_int || bus.int_out !== 1'b0) begin
      failures++;
      $display("FAIL %s inta1: latch=%0b int=%h int_out=%0b want latch=%0b int=%h int_out=0",
               tag, bus.latch_in_service, bus.interrupt, bus.int_out, !spur, exp_int);
    end
    bus.pending_request = 8'd0;
    repeat (gap) step();
    bus.inta_n = 1'b1;
    step();
    repeat (gap) step();
    bus.inta_n = 1'b0;
    step();
    checks++;
    if (bus.data_out_en !== 1'b1 || bus.data_out !== {base, 3'(lvl)}) begin
      failures++;
      $display("FAIL %s vector: en=%0b data=%h want en=1 data=%h", tag, bus.data_out_en,
               bus.data_out, {base, 3'(lvl)});
    end
    repeat (gap) step();
    checks++;
    if (bus.data_out_en !== 1'b1) begin
      failures++;
      $display("FAIL %s en_hold: got %0b want 1", tag, bus.data_out_en);
    end
    exp_eoi = (aeoi && !spur) ? (8'd1 << lvl) : 8'd0;
    if (aeoi && !spur && m_auto) m_rot = lvl;
    if (ocw_en) begin
      model_ocw2(ocw, hi, ocw_eoi);
      exp_eoi = exp_eoi | ocw_eoi;
      bus.ocw2_write = 1'b1;
      bus.ocw2_data = ocw;
    end
    bus.inta_n = 1'b1;
    step();
    bus.ocw2_write = 1'b0;
    checks++;
    if (bus.data_out_en !== 1'b0 || bus.end_of_interrupt !== exp_eoi ||
        bus.priority_rotate !== 3'(m_rot)) begin
      failures++;
      $display("FAIL %s inta2_rise: en=%0b eoi=%h rot=%0d want en=0 eoi=%h rot=%0d", tag,
               bus.data_out_en, bus.end_of_interrupt, bus.priority_rotate, exp_eoi, m_rot);
    end
    step();
    checks++;
    if (bus.end_of_interrupt !== 8'd0) begin
      failures++;
      $display("FAIL %s eoi_pulse: got %h want 00", tag, bus.end_of_interrupt);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_dut();
    checks++;
    if ({bus.int_out, bus.latch_in_service, bus.interrupt, bus.end_of_interrupt,
         bus.data_out, bus.data_out_en} !== 35'd0 || bus.priority_rotate !== 3'd7) begin
      failures++;
      $display("FAIL reset_state: int_out=%0b latch=%0b int=%h eoi=%h dout=%h en=%0b rot=%0d",
               bus.int_out, bus.latch_in_service, bus.interrupt, bus.end_of_interrupt,
               bus.data_out, bus.data_out_en, bus.priority_rotate);
    end
  endtask

  task automatic test_basic();
    run_ack("basic", 8'h24, 8'h00, 5'h08, 1'b0, 1'b0, 0, 1'b0, 8'h00);
  endtask

  task automatic test_priority_block();
    int hi;
    logic [7:0] e;
    bit want;
    set_isr(8'h02, hi);
    bus.pending_request = 8'h08;
    repeat (3) step();
    checks++;
    if (bus.int_out !== 1'b0) begin
      failures++;
      $display("FAIL prio_block: int_out got %0b want 0", bus.int_out);
    end
    ocw2(8'hC1, hi, e);
    checks++;
    if (bus.priority_rotate !== 3'd1) begin
      failures++;
      $display("FAIL set_priority: rot got %0d want 1", bus.priority_rotate);
    end
    set_isr(8'h02, hi);
    want = req_ok(8'h08, 8'h02, m_rot);
    step();
    checks++;
    if (bus.int_out !== want) begin
      failures++;
      $display("FAIL prio_rotated: int_out got %0b want %0b", bus.int_out, want);
    end
    reset_dut();
  endtask

  task automatic test_spurious();
    run_ack("spurious", 8'h10, 8'h00, 5'h1F, 1'b1, 1'b1, 1, 1'b0, 8'h00);
  endtask

  task automatic test_aeoi_rotate();
    int hi;
    logic [7:0] e;
    set_isr(8'h00, hi);
    ocw2(8'h80, hi, e);
    run_ack("aeoi_rot", 8'h08, 8'h00, 5'h0A, 1'b1, 1'b0, 0, 1'b0, 8'h00);
    ocw2(8'h00, hi, e);
  endtask

  task automatic test_ocw2();
    logic [7:0] codes [4] = '{8'hA0, 8'hE6, 8'hA0, 8'h62};
    logic [7:0] isrs [4] = '{8'h10, 8'h10, 8'h00, 8'h00};
    int hi;
    logic [7:0] e;
    for (int i = 0; i < 4; i++) begin
      set_isr(isrs[i], hi);
      ocw2(codes[i], hi, e);
      checks++;
      if (bus.end_of_interrupt !== e || bus.priority_rotate !== 3'(m_rot)) begin
        failures++;
        $display("FAIL ocw2_%h: eoi=%h rot=%0d want eoi=%h rot=%0d", codes[i],
                 bus.end_of_interrupt, bus.priority_rotate, e, m_rot);
      end
      step();
      checks++;
      if (bus.end_of_interrupt !== 8'd0) begin
        failures++;
        $display("FAIL ocw2_pulse_%h: eoi got %h want 00", codes[i], bus.end_of_interrupt);
      end
    end
    reset_dut();
  endtask

  task automatic test_timeout();
    int n;
    // WAIT1 abandons after ACK_TIMEOUT cycles with int_out held.
    bus.pending_request = 8'h01;
    step();
    n = 0;
    while (bus.int_out === 1'b1 && n < 2 * ACK_TIMEOUT) begin
      step();
      n++;
    end
    bus.pending_request = 8'h00;
    checks++;
    if (n != ACK_TIMEOUT) begin
      failures++;
      $display("FAIL wait1_timeout: int_out high %0d cycles want %0d", n, ACK_TIMEOUT);
    end
    step();
    // WAIT2: last-chance edge still accepted, one cycle later it is not.
    for (int late = 0; late < 2; late++) begin
      bus.pending_request = 8'h01;
      step();
      bus.inta_n = 1'b0;
      step();
      bus.pending_request = 8'h00;
      bus.inta_n = 1'b1;
      step();
      repeat (ACK_TIMEOUT - 1 + late) step();
      bus.inta_n = 1'b0;
      step();
      checks++;
      if (bus.data_out_en !== (late == 0) || bus.int_out !== 1'b0) begin
        failures++;
        $display("FAIL wait2_timeout_%0d: en=%0b int_out=%0b want en=%0b int_out=0", late,
                 bus.data_out_en, bus.int_out, late == 0);
      end
      bus.inta_n = 1'b1;
      step();
      step();
    end
    // ACK2: data_out_en drops when INTA stays low too long.
    bus.pending_request = 8'h01;
    step();
    bus.inta_n = 1'b0;
    step();
    bus.pending_request = 8'h00;
    bus.inta_n = 1'b1;
    step();
    bus.inta_n = 1'b0;
    step();
    n = 0;
    while (bus.data_out_en === 1'b1 && n < 2 * ACK_TIMEOUT) begin
      step();
      n++;
    end
    checks++;
    if (n != ACK_TIMEOUT || bus.end_of_interrupt !== 8'd0) begin
      failures++;
      $display("FAIL ack2_timeout: en high %0d cycles eoi=%h want %0d eoi=00", n,
               bus.end_of_interrupt, ACK_TIMEOUT);
    end
    bus.inta_n = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_ack();
    bus.pending_request = 8'h04;
    bus.vector_base = 5'h15;
    step();
    bus.inta_n = 1'b0;
    step();
    bus.inta_n = 1'b1;
    step();
    bus.inta_n = 1'b0;
    step();
    checks++;
    if (bus.data_out_en !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_en: got %0b want 1", bus.data_out_en);
    end
    reset = 1'b1;
    bus.highest_level_in_service = 8'h04;
    bus.in_service_register = 8'h04;
    bus.ocw2_write = 1'b1;
    bus.ocw2_data = 8'hE2;
    step();
    checks++;
    if ({bus.int_out, bus.latch_in_service, bus.interrupt, bus.end_of_interrupt,
         bus.data_out, bus.data_out_en} !== 35'd0 || bus.priority_rotate !== 3'd7) begin
      failures++;
      $display("FAIL reset_mid_ack: en=%0b eoi=%h dout=%h rot=%0d int_out=%0b want all 0 rot=7",
               bus.data_out_en, bus.end_of_interrupt, bus.data_out, bus.priority_rotate,
               bus.int_out);
    end
    reset_dut();
  endtask

  task automatic test_random();
    int hi;
    logic [7:0] e;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        set_isr(8'h00, hi);
        ocw2({3'b110, 2'b00, 3'($urandom_range(0, 7))}, hi, e);
        checks++;
        if (bus.priority_rotate !== 3'(m_rot)) begin
          failures++;
          $display("FAIL rnd_setprio_%0d: rot got %0d want %0d", i, bus.priority_rotate, m_rot);
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        set_isr(8'h00, hi);
        ocw2({2'b00, 1'($urandom_range(0, 1)), 5'b00000} ^ 8'h80, hi, e);
      end
      run_ack("random", 8'($urandom), 8'($urandom & $urandom & $urandom), 5'($urandom),
              1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, $urandom_range(0, 2),
              $urandom_range(0, 2) == 0, {3'($urandom), 2'b00, 3'($urandom)});
    end
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_basic();
    test_priority_block();
    test_spurious();
    test_aeoi_rotate();
    test_ocw2();
    test_timeout();
    test_reset_mid_ack();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
